// File: rtl/seq_logic_sched_if.sv
// Request, datapath and response signals of seq_logic_sched; 'slave' is the scheduler side.
// No storage; N_REQ and ID_W must match the scheduler instance.
interface seq_logic_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) ();
    logic [N_REQ-1:0]   req_valid_i;
    logic [N_REQ-1:0]   req_ready_o;
    logic [N_REQ*8-1:0] req_a_i;
    logic [N_REQ*8-1:0] req_b_i;
    logic [N_REQ-1:0]   req_c_i;
    logic [N_REQ-1:0]   req_d_i;
    logic [7:0]         dp_a_o;
    logic [7:0]         dp_b_o;
    logic               dp_c_o;
    logic               dp_d_o;
    logic               dp_res_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [ID_W-1:0]    rsp_id_o;
    logic               rsp_res_o;
    logic               busy_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_c_i, req_d_i, dp_res_i, rsp_ready_i,
        output req_ready_o, dp_a_o, dp_b_o, dp_c_o, dp_d_o, rsp_valid_o, rsp_id_o,
               rsp_res_o, busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_c_i, req_d_i, dp_res_i, rsp_ready_i,
        input  req_ready_o, dp_a_o, dp_b_o, dp_c_o, dp_d_o, rsp_valid_o, rsp_id_o,
               rsp_res_o, busy_o
    );
endinterface

// File: rtl/seq_logic_sched.sv
// Round-robin scheduler sharing one fixed-latency datapath; response valid DP_LATENCY+2 cycles after grant.
// One operation in flight; a stalled response holds its result and blocks all new grants.
module seq_logic_sched #(
    parameter int N_REQ      = 4,
    parameter int DP_LATENCY = 1,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    seq_logic_sched_if.slave bus
);
    localparam int CNT_W = (DP_LATENCY > 0) ? $clog2(DP_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   scan;
    logic            gnt_vld;
    logic [ID_W+2:0] op_lsb;
    logic            launch;
    logic            capture;

    // Scan from the farthest offset down so the requester nearest ptr wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan = {1'b0, ptr} + (ID_W + 1)'(i);
            if (scan >= (ID_W + 1)'(N_REQ)) begin
                scan = scan - (ID_W + 1)'(N_REQ);
            end
            if (bus.req_valid_i[scan[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[ID_W-1:0];
            end
        end
    end

    assign op_lsb  = {gnt_idx, 3'b000};
    assign launch  = (state == IDLE) && gnt_vld;
    assign capture = (state == WAIT) && (cnt == '0);
    assign ptr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        bus.req_ready_o = '0;
        if (launch && rst_ni) begin
            bus.req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (bus.rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.dp_a_o    <= '0;
            bus.dp_b_o    <= '0;
            bus.dp_c_o    <= 1'b0;
            bus.dp_d_o    <= 1'b0;
            bus.rsp_id_o  <= '0;
            bus.rsp_res_o <= 1'b0;
            gnt_id        <= '0;
            cnt           <= '0;
            ptr           <= '0;
        end else begin
            if (launch) begin
                bus.dp_a_o <= bus.req_a_i[op_lsb +: 8];
                bus.dp_b_o <= bus.req_b_i[op_lsb +: 8];
                bus.dp_c_o <= bus.req_c_i[gnt_idx];
                bus.dp_d_o <= bus.req_d_i[gnt_idx];
                gnt_id     <= gnt_idx;
                cnt        <= CNT_W'(DP_LATENCY);
                ptr        <= ptr_nxt;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                bus.rsp_res_o <= bus.dp_res_i;
                bus.rsp_id_o  <= gnt_id;
            end
        end
    end

    assign bus.rsp_valid_o = (state == RESP);
    assign bus.busy_o      = (state != IDLE);
endmodule

// File: tb/tb_seq_logic_sched.sv
// Bench for seq_logic_sched: timeline model of the DP_LATENCY=1 instance plus directed checks,
// and two extra instances for the DP_LATENCY=0 and DP_LATENCY=3 response timing.
module tb_seq_logic_sched;
    localparam int N    = 4;
    localparam int LAT1 = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_logic_sched_if #(.N_REQ(N), .ID_W(2)) b0 ();
    seq_logic_sched_if #(.N_REQ(N), .ID_W(2)) b1 ();
    seq_logic_sched_if #(.N_REQ(N), .ID_W(2)) b3 ();

    seq_logic_sched #(.N_REQ(N), .DP_LATENCY(0),    .ID_W(2)) d0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));
    seq_logic_sched #(.N_REQ(N), .DP_LATENCY(LAT1), .ID_W(2)) d1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));
    seq_logic_sched #(.N_REQ(N), .DP_LATENCY(3),    .ID_W(2)) d3 (.clk_i(clk), .rst_ni(rst_n), .bus(b3));

    function automatic logic ref_fn(input logic [7:0] a, input logic [7:0] b, input logic c, input logic d);
        return ^{a, b, c, d};
    endfunction

    // Datapath stand-ins with 0, 1 and 3 cycles of latency.
    logic       res1_q = 1'b0;
    logic [2:0] pipe3  = 3'b000;
    always @(posedge clk) res1_q <= ref_fn(b1.dp_a_o, b1.dp_b_o, b1.dp_c_o, b1.dp_d_o);
    always @(posedge clk) pipe3  <= {pipe3[1:0], ref_fn(b3.dp_a_o, b3.dp_b_o, b3.dp_c_o, b3.dp_d_o)};
    assign b0.dp_res_i = ref_fn(b0.dp_a_o, b0.dp_b_o, b0.dp_c_o, b0.dp_d_o);
    assign b1.dp_res_i = res1_q;
    assign b3.dp_res_i = pipe3[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: an operation granted at T0 has age k in cycle Tk and becomes a response after T(1+LAT1).
    int         m_ptr = 0, m_age = -1, m_gid = 0, m_id = 0;
    bit         m_resp = 1'b0;
    logic [7:0] m_a = '0, m_b = '0;
    logic       m_c = 1'b0, m_d = 1'b0, m_res = 1'b0;

    always @(negedge clk) begin : model
        logic [3:0]  exp_rdy;
        logic [31:0] act_v, exp_v;
        int          g, j;
        exp_rdy = '0;
        g = -1;
        act_v = {5'd0, b1.req_ready_o, b1.rsp_valid_o, b1.rsp_id_o, b1.rsp_res_o, b1.busy_o,
                 b1.dp_a_o, b1.dp_b_o, b1.dp_c_o, b1.dp_d_o};
        if (!rst_n) begin
            chk("reset_outputs", act_v, 32'd0);
            m_ptr = 0; m_age = -1; m_gid = 0; m_id = 0; m_resp = 1'b0;
            m_a = '0; m_b = '0; m_c = 1'b0; m_d = 1'b0; m_res = 1'b0;
        end else begin
            if (!m_resp && m_age < 0) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && b1.req_valid_i[j]) g = j;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            exp_v = {5'd0, exp_rdy, m_resp, 2'(m_id), m_res, (m_resp || m_age >= 0),
                     m_a, m_b, m_c, m_d};
            chk("model_outputs", act_v, exp_v);
            if (m_resp) begin
                if (b1.rsp_ready_i) m_resp = 1'b0;
            end else if (m_age >= 0) begin
                if (m_age == 1 + LAT1) begin
                    m_resp = 1'b1;
                    m_age  = -1;
                    m_id   = m_gid;
                    m_res  = ref_fn(m_a, m_b, m_c, m_d);
                end else begin
                    m_age++;
                end
            end else if (g >= 0) begin
                m_age = 1;
                m_gid = g;
                m_a   = b1.req_a_i[8*g +: 8];
                m_b   = b1.req_b_i[8*g +: 8];
                m_c   = b1.req_c_i[g];
                m_d   = b1.req_d_i[g];
                m_ptr = (g + 1) % N;
            end
        end
    end

    int gids[5];
    int gcyc[5];
    int n_gnt;

    task automatic collect(input int want);
        n_gnt = 0;
        for (int k = 0; k < 60 && n_gnt < want; k++) begin
            @(negedge clk);
            if (b1.req_ready_o != 4'b0000) begin
                for (int i = 0; i < N; i++) begin
                    if (b1.req_ready_o[i]) gids[n_gnt] = i;
                end
                gcyc[n_gnt] = cyc;
                n_gnt++;
            end
            tick();
        end
        chk("collect_count", n_gnt, want);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!b1.busy_o) break;
            tick();
        end
        chk("idle_timeout", (k < 50), 1);
        tick();
    endtask

    initial begin
        int lat0, lat3, k;
        b0.req_valid_i = '0; b0.req_a_i = '0; b0.req_b_i = '0; b0.req_c_i = '0; b0.req_d_i = '0; b0.rsp_ready_i = 1'b1;
        b1.req_valid_i = '0; b1.req_a_i = '0; b1.req_b_i = '0; b1.req_c_i = '0; b1.req_d_i = '0; b1.rsp_ready_i = 1'b1;
        b3.req_valid_i = '0; b3.req_a_i = '0; b3.req_b_i = '0; b3.req_c_i = '0; b3.req_d_i = '0; b3.rsp_ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", b1.busy_o, 0);

        // Single request from requester 2: a=1 b=4 c=1 d=0, result parity = 1.
        tick();
        b1.req_valid_i = 4'b0100;
        b1.req_a_i[23:16] = 8'd1; b1.req_b_i[23:16] = 8'd4; b1.req_c_i[2] = 1'b1; b1.req_d_i[2] = 1'b0;
        @(negedge clk); chk("t1_ready", b1.req_ready_o, 4'b0100);
        tick(); b1.req_valid_i = '0;
        @(negedge clk); chk("t1_dp_a", b1.dp_a_o, 8'd1); chk("t1_dp_b", b1.dp_b_o, 8'd4);
        @(negedge clk); chk("t1_t2_no_rsp", b1.rsp_valid_o, 0);
        @(negedge clk); chk("t1_rsp_valid", b1.rsp_valid_o, 1);
        chk("t1_rsp_id", b1.rsp_id_o, 2); chk("t1_rsp_res", b1.rsp_res_o, 1);

        // All four valid from ptr=0: grants 0,1,2,3,0 four cycles apart.
        tick(); rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        b1.req_a_i = 32'h4433_2211; b1.req_b_i = 32'h0703_0100;
        b1.req_c_i = 4'b1010;       b1.req_d_i = 4'b0110;
        b1.req_valid_i = 4'hF;
        collect(5);
        b1.req_valid_i = '0;
        for (int i = 0; i < 5; i++) chk("t2_grant_order", gids[i], i % 4);
        for (int i = 1; i < 5; i++) chk("t2_grant_spacing", gcyc[i] - gcyc[i-1], 4);

        // Backpressure: requester 3 (a=44 b=07 c=1 d=0, result 0) held in RESP; requester 1 waits.
        wait_idle();
        b1.req_valid_i = 4'b1000; b1.rsp_ready_i = 1'b0;
        @(negedge clk); chk("t3_grant3", b1.req_ready_o, 4'b1000);
        tick(); b1.req_valid_i = 4'b0010;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b1.rsp_valid_o) break;
            tick();
        end
        chk("t3_rsp_seen", (k < 20), 1);
        repeat (10) begin
            tick();
            @(negedge clk);
            chk("t3_hold_valid", b1.rsp_valid_o, 1);
            chk("t3_hold_id", b1.rsp_id_o, 3);
            chk("t3_hold_res", b1.rsp_res_o, 0);
            chk("t3_no_ready", b1.req_ready_o, 4'b0000);
        end
        tick(); b1.rsp_ready_i = 1'b1;
        @(negedge clk); chk("t3_handshake_valid", b1.rsp_valid_o, 1);
        tick();
        @(negedge clk); chk("t3_next_grant", b1.req_ready_o, 4'b0010);
        tick(); b1.req_valid_i = '0;

        // Fairness skip: move ptr to 1, then requesters 0 and 3 valid -> 3 then 0.
        wait_idle();
        b1.req_valid_i = 4'b0001;
        @(negedge clk); chk("t4_setup_grant0", b1.req_ready_o, 4'b0001);
        tick(); b1.req_valid_i = '0;
        wait_idle();
        b1.req_valid_i = 4'b1001;
        collect(2);
        b1.req_valid_i = '0;
        chk("t4_first", gids[0], 3);
        chk("t4_second", gids[1], 0);

        // Reset during WAIT after granting requester 2 (ptr would be 3).
        wait_idle();
        b1.req_valid_i = 4'b0100; b1.req_a_i[23:16] = 8'hA5;
        @(negedge clk); chk("t5_grant2", b1.req_ready_o, 4'b0100);
        tick(); b1.req_valid_i = '0;
        #2 rst_n = 1'b0;
        #1 chk("t5_async_clear", {b1.busy_o, b1.dp_a_o, b1.rsp_valid_o, b1.req_ready_o}, 0);
        tick(); tick(); rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk); chk("t5_no_rsp", b1.rsp_valid_o, 0);
            tick();
        end
        b1.req_valid_i = 4'b1010;
        @(negedge clk); chk("t5_ptr_zero", b1.req_ready_o, 4'b0010);
        tick(); b1.req_valid_i = '0;
        wait_idle();

        // Latency 0 and 3: a=03 b=00 c=0 d=1 gives result 1.
        b0.req_a_i[7:0] = 8'h03; b0.req_d_i[0] = 1'b1; b0.req_valid_i = 4'b0001;
        b3.req_a_i[7:0] = 8'h03; b3.req_d_i[0] = 1'b1; b3.req_valid_i = 4'b0001;
        @(negedge clk);
        chk("t6_l0_ready", b0.req_ready_o, 4'b0001);
        chk("t6_l3_ready", b3.req_ready_o, 4'b0001);
        tick(); b0.req_valid_i = '0; b3.req_valid_i = '0;
        lat0 = -1; lat3 = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (b0.rsp_valid_o && lat0 < 0) begin
                lat0 = c; chk("t6_l0_res", b0.rsp_res_o, 1);
            end
            if (b3.rsp_valid_o && lat3 < 0) begin
                lat3 = c; chk("t6_l3_res", b3.rsp_res_o, 1);
            end
            tick();
        end
        chk("t6_l0_latency", lat0, 2);
        chk("t6_l3_latency", lat3, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end
endmodule
